// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch: instruction-fetch responder sitting after the PC.
//
// Takes the PC value and its active flag, runs an Avalon-style read handshake
// against instruction memory (read held stable while waitrequest is high),
// and loads the IF/ID register. It stalls the PC while a fetch is
// outstanding or decode is backed up, and flushes wrong-path instructions
// when a taken branch or jump redirects the PC.
//
// Optional build macro:
//   FETCH_PERF_EN - adds the perf_fetched / perf_stall 32-bit counters.
//
// Reset is asynchronous and active-high.
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter logic [DW-1:0]   NOP_WORD = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_in,
    input  logic          pc_active,
    input  logic          redirect,
    input  logic          id_stall,
    output logic [AW-1:0] imem_addr,
    output logic          imem_read,
    input  logic          imem_waitrequest,
    input  logic [DW-1:0] imem_readdata,
    output logic          pc_stall,
    output logic [DW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    output logic          if_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall
`endif
);

    // IDLE: no request. FETCH: read asserted. HOLD: accepted word parked
    // in the hold buffer because decode could not take it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          read_q, read_d;
    logic          pend_q, pend_d;      // request issued last cycle, still waiting
    logic [AW-1:0] addr_q, addr_d;      // address of the in-flight request
    logic          flush_q, flush_d;    // in-flight request is wrong-path
    logic [DW-1:0] hold_instr_q, hold_instr_d;
    logic [AW-1:0] hold_pc_q, hold_pc_d;
    logic          hold_valid_q, hold_valid_d;
    logic [DW-1:0] if_instr_q, if_instr_d;
    logic [AW-1:0] if_pc_q, if_pc_d;
    logic          if_valid_q, if_valid_d;

    logic          accept;   // handshake completes this cycle
    logic          waiting;  // request asserted but memory not ready
    logic          discard;  // an accept this cycle must not reach IF/ID
    logic          keep;     // an accept this cycle delivers a real instruction

    assign accept  = read_q & ~imem_waitrequest;
    assign waiting = read_q & imem_waitrequest;
    assign discard = flush_q | redirect | ~pc_active;
    assign keep    = accept & ~discard;

    // A fresh request presents the live PC; a waiting request replays the
    // captured address so the bus sees a stable transaction until accept.
    assign imem_addr = (read_q && !pend_q) ? pc_in : addr_q;
    assign imem_read = read_q;

    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;
    assign if_valid = if_valid_q;

    // PC hold decode: a redirect always lets the PC load its target.
    // In HOLD the PC is released on the cycle decode drains the buffer,
    // because the held word's PC was already consumed at accept time;
    // holding one more cycle would fetch that address twice.
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path through the block leaves it unassigned (which would infer a latch).
        pc_stall = 1'b0;
        if (!redirect) begin
            unique case (state_q)
                ST_FETCH: pc_stall = waiting | flush_q | id_stall;
                ST_HOLD:  pc_stall = id_stall;
                default:  pc_stall = 1'b0;
            endcase
        end
    end

    // Next-state and datapath decode for the fetch FSM and IF/ID register.
    always_comb begin
        state_d      = state_q;
        pend_d       = waiting;
        addr_d       = read_q ? imem_addr : addr_q;
        flush_d      = flush_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        hold_valid_d = hold_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        if_valid_d   = if_valid_q;

        // The wrong-path marker lives exactly until its transaction ends.
        if (accept) begin
            flush_d = 1'b0;
        end
        if (redirect && waiting) begin
            flush_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pc_active) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (accept) begin
                    if (!pc_active) begin
                        state_d = ST_IDLE;
                    end else if (keep && id_stall) begin
                        state_d      = ST_HOLD;
                        hold_instr_d = imem_readdata;
                        hold_pc_d    = imem_addr;
                        hold_valid_d = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                    if (keep && !id_stall) begin
                        if_instr_d = imem_readdata;
                        if_pc_d    = imem_addr;
                        if_valid_d = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    hold_valid_d = 1'b0;
                    state_d      = pc_active ? ST_FETCH : ST_IDLE;
                end else if (!id_stall) begin
                    if_instr_d   = hold_instr_q;
                    if_pc_d      = hold_pc_q;
                    if_valid_d   = hold_valid_q;
                    hold_valid_d = 1'b0;
                    state_d      = pc_active ? ST_FETCH : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Redirect wins over everything, including a stalled decode: the
        // instruction in IF/ID is wrong-path and becomes a bubble.
        if (redirect) begin
            if_valid_d   = 1'b0;
            if_instr_d   = NOP_WORD;
            hold_valid_d = 1'b0;
        end

        read_d = (state_d == ST_FETCH);
    end

    // State, request and IF/ID registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            read_q       <= 1'b0;
            pend_q       <= 1'b0;
            addr_q       <= '0;
            flush_q      <= 1'b0;
            hold_instr_q <= NOP_WORD;
            hold_pc_q    <= '0;
            hold_valid_q <= 1'b0;
            if_instr_q   <= NOP_WORD;
            if_pc_q      <= '0;
            if_valid_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            state_q      <= state_d;
            read_q       <= read_d;
            pend_q       <= pend_d;
            addr_q       <= addr_d;
            flush_q      <= flush_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            hold_valid_q <= hold_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            if_valid_q   <= if_valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Performance counters: delivered fetches and PC stall cycles, wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (keep) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (pc_stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch: table-driven bench for instr_fetch.
// Each table row holds one cycle's inputs plus the outputs expected in that
// cycle (combinational outputs for those inputs, registered outputs as left
// by the previous edge). Inputs are driven on the falling edge and outputs
// sampled 1 ns later. Hand-written sequences cover an asynchronous reset
// mid-transaction and the optional performance counters (FETCH_PERF_EN).
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_in;
    logic          pc_active;
    logic          redirect;
    logic          id_stall;
    logic [AW-1:0] imem_addr;
    logic          imem_read;
    logic          imem_waitrequest;
    logic [DW-1:0] imem_readdata;
    logic          pc_stall;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          if_valid;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_stall;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.AW(AW), .DW(DW), .NOP_WORD(NOP)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_in            (pc_in),
        .pc_active        (pc_active),
        .redirect         (redirect),
        .id_stall         (id_stall),
        .imem_addr        (imem_addr),
        .imem_read        (imem_read),
        .imem_waitrequest (imem_waitrequest),
        .imem_readdata    (imem_readdata),
        .pc_stall         (pc_stall),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .if_valid         (if_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_stall       (perf_stall)
`endif
    );

    typedef struct {
        logic        rst;
        logic        act;
        logic        redir;
        logic        ids;
        logic        wr;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        e_read;
        logic        e_stall;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got 0x%08h, expected 0x%08h", name, row, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst_v, input logic act, input logic redir,
                                input logic ids, input logic wr,
                                input logic [31:0] pc, input logic [31:0] rdata,
                                input logic e_read, input logic e_stall,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_ifpc, input logic [31:0] e_instr);
        vec_t v;
        v.rst = rst_v; v.act = act; v.redir = redir; v.ids = ids; v.wr = wr;
        v.pc = pc; v.rdata = rdata;
        v.e_read = e_read; v.e_stall = e_stall; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_ifpc = e_ifpc; v.e_instr = e_instr;
        return v;
    endfunction

    // One cycle of free-running fetch stimulus; read data tags its address.
    task automatic drive(input logic act, input logic [31:0] pc, input logic wr);
        @(negedge clk);
        pc_active        = act;
        pc_in            = pc;
        imem_waitrequest = wr;
        imem_readdata    = 32'hC0DE_0000 | pc;
        redirect         = 1'b0;
        id_stall         = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        pc_in            = '0;
        pc_active        = 1'b0;
        redirect         = 1'b0;
        id_stall         = 1'b0;
        imem_waitrequest = 1'b0;
        imem_readdata    = '0;

        //            rst act rdr ids wr  pc         rdata          rd st addr       vl if_pc      if_instr
        // reset held for three cycles
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,     32'h0,         0, 0, 32'h0,     0, 32'h0,     NOP));
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,     32'h0,         0, 0, 32'h0,     0, 32'h0,     NOP));
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,     32'h0,         0, 0, 32'h0,     0, 32'h0,     NOP));
        // release, PC active; read rises one cycle later, one instr per cycle
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,     32'h0,         0, 0, 32'h0,     0, 32'h0,     NOP));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,     32'hC0DE_0000, 1, 0, 32'h0,     0, 32'h0,     NOP));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h4,     32'hC0DE_0004, 1, 0, 32'h4,     1, 32'h0,     32'hC0DE_0000));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h8,     32'hC0DE_0008, 1, 0, 32'h8,     1, 32'h4,     32'hC0DE_0004));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'hC,     32'hC0DE_000C, 1, 0, 32'hC,     1, 32'h8,     32'hC0DE_0008));
        // waitrequest for three cycles at 0x10
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h10,    32'h0,         1, 1, 32'h10,    1, 32'hC,     32'hC0DE_000C));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h10,    32'h0,         1, 1, 32'h10,    1, 32'hC,     32'hC0DE_000C));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h10,    32'h0,         1, 1, 32'h10,    1, 32'hC,     32'hC0DE_000C));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h10,    32'hC0DE_0010, 1, 0, 32'h10,    1, 32'hC,     32'hC0DE_000C));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h14,    32'hC0DE_0014, 1, 0, 32'h14,    1, 32'h10,    32'hC0DE_0010));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h18,    32'hC0DE_0018, 1, 0, 32'h18,    1, 32'h14,    32'hC0DE_0014));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h1C,    32'hC0DE_001C, 1, 0, 32'h1C,    1, 32'h18,    32'hC0DE_0018));
        // id_stall for two cycles at 0x20: accept into HOLD, then drain
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h20,    32'hC0DE_0020, 1, 1, 32'h20,    1, 32'h1C,    32'hC0DE_001C));
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h20,    32'h0,         0, 1, 32'h0,     1, 32'h1C,    32'hC0DE_001C));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h20,    32'h0,         0, 0, 32'h0,     1, 32'h1C,    32'hC0DE_001C));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h24,    32'hC0DE_0024, 1, 0, 32'h24,    1, 32'h20,    32'hC0DE_0020));
        // redirect to 0xFFF4 during streaming fetch; same-cycle accept dropped
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h28,    32'hC0DE_0028, 1, 0, 32'h28,    1, 32'h24,    32'hC0DE_0024));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'hFFF4,  32'hC0DE_FFF4, 1, 0, 32'hFFF4,  0, 32'h24,    NOP));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'hFFF8,  32'hC0DE_FFF8, 1, 0, 32'hFFF8,  1, 32'hFFF4,  32'hC0DE_FFF4));
        // redirect to 0x40, then redirect to 0x0 while the 0x40 read waits
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'hFFFC,  32'hC0DE_FFFC, 1, 0, 32'hFFFC,  1, 32'hFFF8,  32'hC0DE_FFF8));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h40,    32'h0,         1, 1, 32'h40,    0, 32'hFFF8,  NOP));
        vecs.push_back(mk(0, 1, 1, 0, 1, 32'h40,    32'h0,         1, 0, 32'h40,    0, 32'hFFF8,  NOP));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0,     32'h0,         1, 1, 32'h40,    0, 32'hFFF8,  NOP));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,     32'hDEAD_BEEF, 1, 1, 32'h40,    0, 32'hFFF8,  NOP));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,     32'hC0DE_0000, 1, 0, 32'h0,     0, 32'hFFF8,  NOP));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h4,     32'hC0DE_0004, 1, 0, 32'h4,     1, 32'h0,     32'hC0DE_0000));
        // pc_active falls while a read waits: completes, discarded, IDLE
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h8,     32'h0,         1, 1, 32'h8,     1, 32'h4,     32'hC0DE_0004));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h8,     32'hBAD0_0008, 1, 0, 32'h8,     1, 32'h4,     32'hC0DE_0004));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h8,     32'h0,         0, 0, 32'h0,     1, 32'h4,     32'hC0DE_0004));
        // restart; redirect while holding flushes even with id_stall high
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h100,   32'h0,         0, 0, 32'h0,     1, 32'h4,     32'hC0DE_0004));
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h100,   32'hC0DE_0100, 1, 1, 32'h100,   1, 32'h4,     32'hC0DE_0004));
        vecs.push_back(mk(0, 1, 1, 1, 0, 32'h100,   32'h0,         0, 0, 32'h0,     1, 32'h4,     32'hC0DE_0004));
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h200,   32'hC0DE_0200, 1, 1, 32'h200,   0, 32'h4,     NOP));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h200,   32'h0,         0, 0, 32'h0,     0, 32'h4,     NOP));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h204,   32'hC0DE_0204, 1, 0, 32'h204,   1, 32'h200,   32'hC0DE_0200));
        // redirect + accept + id_stall together: flush, no HOLD
        vecs.push_back(mk(0, 1, 1, 1, 0, 32'h208,   32'hC0DE_0208, 1, 0, 32'h208,   1, 32'h204,   32'hC0DE_0204));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h300,   32'hC0DE_0300, 1, 0, 32'h300,   0, 32'h204,   NOP));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h304,   32'hC0DE_0304, 1, 0, 32'h304,   1, 32'h300,   32'hC0DE_0300));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst              = vecs[i].rst;
            pc_active        = vecs[i].act;
            redirect         = vecs[i].redir;
            id_stall         = vecs[i].ids;
            imem_waitrequest = vecs[i].wr;
            pc_in            = vecs[i].pc;
            imem_readdata    = vecs[i].rdata;
            #1;
            check("imem_read", i, 32'(imem_read), 32'(vecs[i].e_read));
            check("pc_stall",  i, 32'(pc_stall),  32'(vecs[i].e_stall));
            check("if_valid",  i, 32'(if_valid),  32'(vecs[i].e_valid));
            check("if_pc",     i, if_pc,          vecs[i].e_ifpc);
            check("if_instr",  i, if_instr,       vecs[i].e_instr);
            if (vecs[i].e_read || vecs[i].rst) begin
                check("imem_addr", i, imem_addr, vecs[i].e_addr);
            end
        end

        // Asynchronous reset while a read is waiting at 0x308.
        drive(1'b1, 32'h308, 1'b1);
        #1;
        check("pre_rst_read",  100, 32'(imem_read), 32'd1);
        check("pre_rst_stall", 100, 32'(pc_stall),  32'd1);
        check("pre_rst_if_pc", 100, if_pc,          32'h304);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_read",     101, 32'(imem_read), 32'd0);
        check("rst_stall",    101, 32'(pc_stall),  32'd0);
        check("rst_if_valid", 101, 32'(if_valid),  32'd0);
        check("rst_if_pc",    101, if_pc,          32'h0);
        check("rst_if_instr", 101, if_instr,       NOP);

        // Release: 5 delivered fetches, 3 waitrequest cycles, then PC stops.
        @(negedge clk);
        rst              = 1'b0;
        pc_active        = 1'b1;
        pc_in            = 32'h0;
        imem_waitrequest = 1'b0;
        drive(1'b1, 32'h0,  1'b0);
        drive(1'b1, 32'h4,  1'b1);
        drive(1'b1, 32'h4,  1'b1);
        drive(1'b1, 32'h4,  1'b1);
        drive(1'b1, 32'h4,  1'b0);
        drive(1'b1, 32'h8,  1'b0);
        drive(1'b1, 32'hC,  1'b0);
        drive(1'b1, 32'h10, 1'b0);
        drive(1'b0, 32'h14, 1'b0);
        #1;
        check("stop_stall", 102, 32'(pc_stall), 32'd0);
        drive(1'b0, 32'h14, 1'b0);
        #1;
        check("stop_read",     103, 32'(imem_read), 32'd0);
        check("stop_if_valid", 103, 32'(if_valid),  32'd1);
        check("stop_if_pc",    103, if_pc,          32'h10);
        check("stop_if_instr", 103, if_instr,       32'hC0DE_0010);
`ifdef FETCH_PERF_EN
        check("perf_fetched", 103, perf_fetched, 32'd5);
        check("perf_stall",   103, perf_stall,   32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
